color_detect_pipe: RTL and testbench

- Pipelined, parametrised successor to the combinational RGB565 colour classifier.
- Classifies each streamed pixel against NUM_CH runtime-programmable colour rules in parallel, using a valid/ready handshake.
- Emits a per-pixel detect mask plus a debug/mask video word.
- Accumulates per-channel detected-pixel counts per frame.
- Sits between the camera capture stream and the frame buffer / object-tracking logic.

---
 rtl/color_detect_pkg.sv | 59 +++++
 rtl/color_detect_pipe_rule_match.sv | 58 +++++
 rtl/color_detect_pipe.sv | 229 ++++++++++++++++++++++
 tb/tb_color_detect_pipe.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_detect_pkg.sv
// Shared types, rule defaults and config-word layout for the colour detector.
package color_detect_pkg;

    typedef enum logic [1:0] {
        DOM_R   = 2'd0,
        DOM_G   = 2'd1,
        DOM_B   = 2'd2,
        DOM_OFF = 2'd3
    } dom_e;

    typedef struct packed {
        logic       enable;
        logic [5:0] other_max;
        logic [5:0] margin;
        logic [5:0] sat_min;
        logic [7:0] sum_min;
        dom_e       dom;
    } rule_t;

    localparam int unsigned CFG_DOM_LSB    = 0;
    localparam int unsigned CFG_SUMMIN_LSB = 2;
    localparam int unsigned CFG_SATMIN_LSB = 10;
    localparam int unsigned CFG_MARGIN_LSB = 16;
    localparam int unsigned CFG_OTHMAX_LSB = 22;
    localparam int unsigned CFG_ENABLE_BIT = 28;

    localparam logic [7:0] DEF_SUM_MIN   = 8'd35;
    localparam logic [5:0] DEF_SAT_MIN   = 6'd4;
    localparam logic [5:0] DEF_MARGIN    = 6'd6;
    localparam logic [5:0] DEF_OTHER_MAX = 6'd24;

    function automatic rule_t default_rule(input int unsigned ch);
        rule_t r;
        r.enable    = 1'b1;
        r.other_max = DEF_OTHER_MAX;
        r.margin    = DEF_MARGIN;
        r.sat_min   = DEF_SAT_MIN;
        r.sum_min   = DEF_SUM_MIN;
        case (ch)
            0:       r.dom = DOM_R;
            1:       r.dom = DOM_G;
            2:       r.dom = DOM_B;
            default: r.dom = DOM_OFF;
        endcase
        return r;
    endfunction

    function automatic rule_t unpack_rule(input logic [31:0] w);
        rule_t r;
        r.dom       = dom_e'(w[CFG_DOM_LSB +: 2]);
        r.sum_min   = w[CFG_SUMMIN_LSB +: 8];
        r.sat_min   = w[CFG_SATMIN_LSB +: 6];
        r.margin    = w[CFG_MARGIN_LSB +: 6];
        r.other_max = w[CFG_OTHMAX_LSB +: 6];
        r.enable    = w[CFG_ENABLE_BIT];
        return r;
    endfunction

endpackage

// File: rtl/color_detect_pipe_rule_match.sv
// One colour rule evaluated against a scaled pixel; purely combinational.
module color_rule_match
    import color_detect_pkg::*;
(
    input  logic [5:0] r6,
    input  logic [5:0] g6,
    input  logic [5:0] b6,
    input  logic [7:0] sum,
    input  logic [5:0] sat,
    input  rule_t      rule,
    output logic       hit
);

    logic [5:0] dom_v;
    logic [5:0] oth_a;
    logic [5:0] oth_b;
    logic [6:0] diff_a;
    logic [6:0] diff_b;
    logic       dom_on;
    logic       ok_a;
    logic       ok_b;

    always_comb begin
        dom_v  = r6;
        oth_a  = g6;
        oth_b  = b6;
        dom_on = 1'b1;
        case (rule.dom)
            DOM_R: begin
                dom_v = r6;
                oth_a = g6;
                oth_b = b6;
            end
            DOM_G: begin
                dom_v = g6;
                oth_a = r6;
                oth_b = b6;
            end
            DOM_B: begin
                dom_v = b6;
                oth_a = r6;
                oth_b = g6;
            end
            default: dom_on = 1'b0;
        endcase

        // Bit 6 is the borrow: a dominant value below the other component fails outright.
        diff_a = {1'b0, dom_v} - {1'b0, oth_a};
        diff_b = {1'b0, dom_v} - {1'b0, oth_b};
        ok_a   = !diff_a[6] && (diff_a[5:0] >= rule.margin) && (oth_a <= rule.other_max);
        ok_b   = !diff_b[6] && (diff_b[5:0] >= rule.margin) && (oth_b <= rule.other_max);

        hit = rule.enable && dom_on
           && (sum >= rule.sum_min) && (sat >= rule.sat_min)
           && ok_a && ok_b;
    end

endmodule

// File: rtl/color_detect_pipe.sv
// Two-stage streaming RGB565 classifier with shadowed rules and per-frame hit counters.
module color_detect_pipe
    import color_detect_pkg::*;
#(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned CNT_W  = 19,
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [15:0]               s_data,
    input  logic                      s_sof,
    input  logic                      s_eof,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [NUM_CH-1:0]         m_mask,
    output logic [15:0]               m_data,
    output logic                      m_sof,
    output logic                      m_eof,
    input  logic [CH_W:0]             mode_sel,
    input  logic                      cfg_wr,
    input  logic [CH_W-1:0]           cfg_idx,
    input  logic [31:0]               cfg_wdata,
    output logic [NUM_CH*CNT_W-1:0]   det_count,
    output logic                      stats_valid
);

    rule_t [NUM_CH-1:0] shadow_q, shadow_d;
    rule_t [NUM_CH-1:0] active_q, active_d;

    logic adv;
    logic s_fire;
    logic m_fire;

    logic [5:0] in_r6, in_g6, in_b6, in_max, in_min;
    logic [7:0] in_sum;

    logic             s1_valid_q, s1_valid_d;
    logic [15:0]      s1_pix_q, s1_pix_d;
    logic [5:0]       s1_r6_q, s1_r6_d;
    logic [5:0]       s1_g6_q, s1_g6_d;
    logic [5:0]       s1_b6_q, s1_b6_d;
    logic [7:0]       s1_sum_q, s1_sum_d;
    logic [5:0]       s1_sat_q, s1_sat_d;
    logic             s1_sof_q, s1_sof_d;
    logic             s1_eof_q, s1_eof_d;
    logic [CH_W:0]    s1_mode_q, s1_mode_d;

    logic [NUM_CH-1:0] hit;
    logic              sel_bit;

    logic              m_valid_q, m_valid_d;
    logic [NUM_CH-1:0] m_mask_q, m_mask_d;
    logic [15:0]       m_data_q, m_data_d;
    logic              m_sof_q, m_sof_d;
    logic              m_eof_q, m_eof_d;

    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
    logic [NUM_CH-1:0][CNT_W-1:0] det_q, det_d;
    logic                         stats_q, stats_d;

    assign adv    = m_ready || !m_valid_q;
    assign s_fire = s_valid && adv;
    assign m_fire = m_valid_q && m_ready;

    // Scaled components, brightness and saturation of the incoming pixel
    always_comb begin
        in_r6  = {s_data[15:11], 1'b0};
        in_g6  = s_data[10:5];
        in_b6  = {s_data[4:0], 1'b0};
        in_max = in_r6;
        if (in_g6 > in_max) in_max = in_g6;
        if (in_b6 > in_max) in_max = in_b6;
        in_min = in_r6;
        if (in_g6 < in_min) in_min = in_g6;
        if (in_b6 < in_min) in_min = in_b6;
        in_sum = 8'(in_r6) + 8'(in_g6) + 8'(in_b6);
    end

    // Active rules take the pre-write shadow, so a same-cycle cfg_wr waits a frame
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (s_fire && s_sof) active_d = shadow_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cfg_wr && (cfg_idx == CH_W'(i))) shadow_d[i] = unpack_rule(cfg_wdata);
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_pix_d   = s1_pix_q;
        s1_r6_d    = s1_r6_q;
        s1_g6_d    = s1_g6_q;
        s1_b6_d    = s1_b6_q;
        s1_sum_d   = s1_sum_q;
        s1_sat_d   = s1_sat_q;
        s1_sof_d   = s1_sof_q;
        s1_eof_d   = s1_eof_q;
        s1_mode_d  = s1_mode_q;
        if (adv) begin
            s1_valid_d = s_valid;
            s1_pix_d   = s_data;
            s1_r6_d    = in_r6;
            s1_g6_d    = in_g6;
            s1_b6_d    = in_b6;
            s1_sum_d   = in_sum;
            s1_sat_d   = in_max - in_min;
            s1_sof_d   = s_valid && s_sof;
            s1_eof_d   = s_valid && s_eof;
            s1_mode_d  = mode_sel;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_rule
        color_rule_match u_match (
            .r6   (s1_r6_q),
            .g6   (s1_g6_q),
            .b6   (s1_b6_q),
            .sum  (s1_sum_q),
            .sat  (s1_sat_q),
            .rule (active_q[g]),
            .hit  (hit[g])
        );
    end

    always_comb begin
        sel_bit = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (s1_mode_q == (CH_W+1)'(i + 1)) sel_bit = hit[i];
        end

        m_valid_d = m_valid_q;
        m_mask_d  = m_mask_q;
        m_data_d  = m_data_q;
        m_sof_d   = m_sof_q;
        m_eof_d   = m_eof_q;
        if (adv) begin
            m_valid_d = s1_valid_q;
            m_mask_d  = hit;
            m_data_d  = (s1_mode_q == '0) ? s1_pix_q : {16{sel_bit}};
            m_sof_d   = s1_valid_q && s1_sof_q;
            m_eof_d   = s1_valid_q && s1_eof_q;
        end
    end

    // sof reloads rather than adds; eof publishes the total including its own pixel
    always_comb begin
        cnt_d   = cnt_q;
        det_d   = det_q;
        cnt_nxt = cnt_q;
        stats_d = m_fire && m_eof_q;
        if (m_fire) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (m_sof_q) begin
                    cnt_nxt[i] = CNT_W'(m_mask_q[i]);
                end else if (cnt_q[i] != '1) begin
                    cnt_nxt[i] = cnt_q[i] + CNT_W'(m_mask_q[i]);
                end
                if (m_eof_q) begin
                    det_d[i] = cnt_nxt[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_nxt[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= default_rule(i);
                active_q[i] <= default_rule(i);
            end
            s1_valid_q <= 1'b0;
            s1_pix_q   <= '0;
            s1_r6_q    <= '0;
            s1_g6_q    <= '0;
            s1_b6_q    <= '0;
            s1_sum_q   <= '0;
            s1_sat_q   <= '0;
            s1_sof_q   <= 1'b0;
            s1_eof_q   <= 1'b0;
            s1_mode_q  <= '0;
            m_valid_q  <= 1'b0;
            m_mask_q   <= '0;
            m_data_q   <= '0;
            m_sof_q    <= 1'b0;
            m_eof_q    <= 1'b0;
            cnt_q      <= '0;
            det_q      <= '0;
            stats_q    <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            s1_valid_q <= s1_valid_d;
            s1_pix_q   <= s1_pix_d;
            s1_r6_q    <= s1_r6_d;
            s1_g6_q    <= s1_g6_d;
            s1_b6_q    <= s1_b6_d;
            s1_sum_q   <= s1_sum_d;
            s1_sat_q   <= s1_sat_d;
            s1_sof_q   <= s1_sof_d;
            s1_eof_q   <= s1_eof_d;
            s1_mode_q  <= s1_mode_d;
            m_valid_q  <= m_valid_d;
            m_mask_q   <= m_mask_d;
            m_data_q   <= m_data_d;
            m_sof_q    <= m_sof_d;
            m_eof_q    <= m_eof_d;
            cnt_q      <= cnt_d;
            det_q      <= det_d;
            stats_q    <= stats_d;
        end
    end

    assign s_ready     = adv;
    assign m_valid     = m_valid_q;
    assign m_mask      = m_mask_q;
    assign m_data      = m_data_q;
    assign m_sof       = m_sof_q;
    assign m_eof       = m_eof_q;
    assign det_count   = det_q;
    assign stats_valid = stats_q;

endmodule

// File: tb/tb_color_detect_pipe.sv
// Scoreboard bench: an independent pixel/rule/counter model predicts every output transfer and stats pulse.
module tb_color_detect_pipe;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 19;
    localparam int CNT_WB = 4;
    localparam int CH_W   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                     s_valid = 1'b0, s_sof = 1'b0, s_eof = 1'b0;
    logic [15:0]              s_data = '0;
    logic                     m_ready = 1'b1;
    logic [CH_W:0]            mode_sel = '0;
    logic                     cfg_wr = 1'b0;
    logic [CH_W-1:0]          cfg_idx = '0;
    logic [31:0]              cfg_wdata = '0;

    logic                     s_ready, m_valid, m_sof, m_eof, stats_valid;
    logic [NUM_CH-1:0]        m_mask;
    logic [15:0]              m_data;
    logic [NUM_CH*CNT_W-1:0]  det_count;

    logic                     s_ready_b, m_valid_b, m_sof_b, m_eof_b, stats_valid_b;
    logic [NUM_CH-1:0]        m_mask_b;
    logic [15:0]              m_data_b;
    logic [NUM_CH*CNT_WB-1:0] det_count_b;

    color_detect_pipe #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sof(s_sof), .s_eof(s_eof), .m_valid(m_valid), .m_ready(m_ready), .m_mask(m_mask),
        .m_data(m_data), .m_sof(m_sof), .m_eof(m_eof), .mode_sel(mode_sel), .cfg_wr(cfg_wr),
        .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata), .det_count(det_count), .stats_valid(stats_valid)
    );

    color_detect_pipe #(.NUM_CH(NUM_CH), .CNT_W(CNT_WB)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
        .s_sof(s_sof), .s_eof(s_eof), .m_valid(m_valid_b), .m_ready(m_ready), .m_mask(m_mask_b),
        .m_data(m_data_b), .m_sof(m_sof_b), .m_eof(m_eof_b), .mode_sel(mode_sel), .cfg_wr(cfg_wr),
        .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata), .det_count(det_count_b), .stats_valid(stats_valid_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int dom, sum_min, sat_min, margin, other_max;
        bit en;
    } m_rule_t;

    typedef struct packed {
        logic [NUM_CH-1:0] mask;
        logic [15:0]       data;
        logic              sof;
        logic              eof;
    } exp_t;

    m_rule_t act[NUM_CH];
    m_rule_t shd[NUM_CH];
    exp_t    exp_q[$];
    logic [NUM_CH*CNT_W-1:0]  cnt_expq[$];
    logic [NUM_CH*CNT_WB-1:0] cntb_expq[$];
    int      mc[NUM_CH];
    int      mcb[NUM_CH];
    int      out_cnt = 0;
    int      stats_seen = 0;
    logic    rand_rdy = 1'b0;
    logic    hold_rdy = 1'b1;

    function automatic m_rule_t def_rule(input int ch);
        m_rule_t r;
        r.dom = (ch < 3) ? ch : 3;
        r.sum_min = 35; r.sat_min = 4; r.margin = 6; r.other_max = 24; r.en = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] mk_cfg(input int dom, input int smin, input int satm,
                                           input int mar, input int omax, input bit en);
        logic [31:0] w;
        w = '0;
        w[1:0] = dom[1:0]; w[9:2] = smin[7:0]; w[15:10] = satm[5:0];
        w[21:16] = mar[5:0]; w[27:22] = omax[5:0]; w[28] = en;
        return w;
    endfunction

    function automatic logic [NUM_CH-1:0] model_mask(input logic [15:0] px);
        int c[3];
        int s, mx, mn;
        bit ok;
        logic [NUM_CH-1:0] m;
        c[0] = 2 * int'(px[15:11]);
        c[1] = int'(px[10:5]);
        c[2] = 2 * int'(px[4:0]);
        s = c[0] + c[1] + c[2];
        mx = c[0]; mn = c[0];
        for (int k = 1; k < 3; k++) begin
            if (c[k] > mx) mx = c[k];
            if (c[k] < mn) mn = c[k];
        end
        m = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            ok = act[ch].en && (act[ch].dom != 3) && (s >= act[ch].sum_min) && ((mx - mn) >= act[ch].sat_min);
            if (ok) begin
                for (int k = 0; k < 3; k++) begin
                    if (k != act[ch].dom) begin
                        if ((c[act[ch].dom] - c[k]) < act[ch].margin || c[k] > act[ch].other_max) ok = 1'b0;
                    end
                end
            end
            m[ch] = ok;
        end
        return m;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < NUM_CH; i++) begin
            act[i] = def_rule(i); shd[i] = def_rule(i); mc[i] = 0; mcb[i] = 0;
        end
        exp_q.delete(); cnt_expq.delete(); cntb_expq.delete();
    endtask

    // Model: input side first (sof swaps rules before classifying), then cfg, then output side
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_valid && s_ready) begin
                exp_t e;
                int md;
                if (s_sof) for (int i = 0; i < NUM_CH; i++) act[i] = shd[i];
                e.mask = model_mask(s_data);
                md = int'(mode_sel);
                if (md == 0) e.data = s_data;
                else if (md <= NUM_CH) e.data = e.mask[md-1] ? 16'hFFFF : 16'h0000;
                else e.data = 16'h0000;
                e.sof = s_sof; e.eof = s_eof;
                exp_q.push_back(e);
            end
            if (cfg_wr && int'(cfg_idx) < NUM_CH) begin
                shd[cfg_idx].dom = int'(cfg_wdata[1:0]);
                shd[cfg_idx].sum_min = int'(cfg_wdata[9:2]);
                shd[cfg_idx].sat_min = int'(cfg_wdata[15:10]);
                shd[cfg_idx].margin = int'(cfg_wdata[21:16]);
                shd[cfg_idx].other_max = int'(cfg_wdata[27:22]);
                shd[cfg_idx].en = cfg_wdata[28];
            end
            if (stats_valid) begin
                stats_seen++;
                if (cnt_expq.size() == 0) check_val("stats_unexpected", 1, 0);
                else check_val("det_count", 64'(det_count), 64'(cnt_expq.pop_front()));
            end
            if (stats_valid_b) begin
                if (cntb_expq.size() == 0) check_val("stats_b_unexpected", 1, 0);
                else check_val("det_count_sat", 64'(det_count_b), 64'(cntb_expq.pop_front()));
            end
            if (m_valid && m_ready) begin
                exp_t e;
                logic [NUM_CH*CNT_W-1:0]  v;
                logic [NUM_CH*CNT_WB-1:0] vb;
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check_val("out_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("m_mask", 64'(m_mask), 64'(e.mask));
                    check_val("m_data", 64'(m_data), 64'(e.data));
                    check_val("m_sof", 64'(m_sof), 64'(e.sof));
                    check_val("m_eof", 64'(m_eof), 64'(e.eof));
                    for (int i = 0; i < NUM_CH; i++) begin
                        int b;
                        b = e.mask[i] ? 1 : 0;
                        if (e.sof) begin mc[i] = b; mcb[i] = b; end
                        else begin
                            mc[i] = (mc[i] + b > 2**CNT_W - 1) ? 2**CNT_W - 1 : mc[i] + b;
                            mcb[i] = (mcb[i] + b > 2**CNT_WB - 1) ? 2**CNT_WB - 1 : mcb[i] + b;
                        end
                        v[i*CNT_W +: CNT_W] = mc[i][CNT_W-1:0];
                        vb[i*CNT_WB +: CNT_WB] = mcb[i][CNT_WB-1:0];
                    end
                    if (e.eof) begin
                        cnt_expq.push_back(v); cntb_expq.push_back(vb);
                        for (int i = 0; i < NUM_CH; i++) begin mc[i] = 0; mcb[i] = 0; end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : hold_rdy;
        end
    end

    task automatic send(input logic [15:0] px, input logic sof, input logic eof);
        int n;
        n = 0;
        s_valid = 1'b1; s_data = px; s_sof = sof; s_eof = eof;
        @(negedge clk);
        while (!s_ready && n < 500) begin n++; @(negedge clk); end
        if (!s_ready) check_val("accept_timeout", 0, 1);
        @(posedge clk); #1;
        s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
    endtask

    task automatic cfg_write(input logic [CH_W-1:0] idx, input logic [31:0] w);
        cfg_wr = 1'b1; cfg_idx = idx; cfg_wdata = w;
        @(posedge clk); #1;
        cfg_wr = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin n++; @(posedge clk); #1; end
        check_val("drain_empty", 64'(exp_q.size()), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_m_valid", 64'(m_valid), 0);
        check_val("rst_stats", 64'(stats_valid), 0);
        check_val("rst_det", 64'(det_count), 0);
        check_val("rst_s_ready", 64'(s_ready), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-pixel red frame, channel 0 shown, two-cycle latency
        mode_sel = 3'd1;
        send(16'hF800, 1'b1, 1'b1);
        check_val("lat_s1_only", 64'(m_valid), 0);
        @(posedge clk); #1;
        check_val("lat_m_valid", 64'(m_valid), 1);
        check_val("lat_m_mask", 64'(m_mask), 64'h1);
        check_val("lat_m_data", 64'(m_data), 64'hFFFF);
        drain();
        check_val("single_ch0", 64'(det_count[0 +: CNT_W]), 1);
        check_val("single_ch1", 64'(det_count[CNT_W +: CNT_W]), 0);
        check_val("single_stats_pulses", 64'(stats_seen), 1);

        // Primary colours and corner pixels, passthrough
        mode_sel = 3'd0;
        send(16'h07E0, 1'b1, 1'b0);
        send(16'h001F, 1'b0, 1'b0);
        send(16'hFFFF, 1'b0, 1'b0);
        send(16'h0000, 1'b0, 1'b1);
        drain();

        // 100-pixel frame under random backpressure
        mode_sel = 3'd2;
        out_cnt = 0;
        rand_rdy = 1'b1;
        for (int i = 0; i < 100; i++) send((i % 2 == 0) ? 16'hF800 : 16'h0000, i == 0, i == 99);
        drain();
        rand_rdy = 1'b0;
        drain();
        check_val("rand_out_count", 64'(out_cnt), 100);
        check_val("rand_ch0", 64'(det_count[0 +: CNT_W]), 50);

        // Counter saturation on the narrow-counter instance
        mode_sel = 3'd4;
        for (int i = 0; i < 21; i++) send(16'hF800, i == 0, i == 20);
        drain();
        check_val("sat_wide_ch0", 64'(det_count[0 +: CNT_W]), 21);
        check_val("sat_narrow_ch0", 64'(det_count_b[0 +: CNT_WB]), 15);

        // Mid-frame config lands at next sof; same-cycle write waits one more frame
        mode_sel = 3'd1;
        send(16'hF800, 1'b1, 1'b0);
        cfg_write(2'd0, mk_cfg(0, 255, 4, 6, 24, 1'b1));
        cfg_write(2'd3, mk_cfg(0, 0, 0, 0, 63, 1'b1));
        send(16'hF800, 1'b0, 1'b0);
        send(16'hF800, 1'b0, 1'b1);
        cfg_wr = 1'b1; cfg_idx = 2'd1; cfg_wdata = mk_cfg(3, 35, 4, 6, 24, 1'b1);
        send(16'hF800, 1'b1, 1'b0);
        cfg_wr = 1'b0;
        send(16'h07E0, 1'b0, 1'b1);
        send(16'h07E0, 1'b1, 1'b1);
        drain();
        check_val("cfg_next_ch0", 64'(det_count[0 +: CNT_W]), 0);
        check_val("cfg_next_ch1", 64'(det_count[CNT_W +: CNT_W]), 0);

        // Asynchronous reset mid-frame with output held valid
        hold_rdy = 1'b0;
        @(posedge clk); #1;
        send(16'hF800, 1'b1, 1'b0);
        send(16'h07E0, 1'b0, 1'b0);
        check_val("pre_rst_m_valid", 64'(m_valid), 1);
        rst_n = 1'b0;
        #1;
        check_val("arst_m_valid", 64'(m_valid), 0);
        check_val("arst_m_mask", 64'(m_mask), 0);
        check_val("arst_m_data", 64'(m_data), 0);
        check_val("arst_markers", 64'({m_sof, m_eof}), 0);
        check_val("arst_stats", 64'(stats_valid), 0);
        check_val("arst_det", 64'(det_count), 0);
        check_val("arst_s_ready", 64'(s_ready), 1);
        reset_model();
        hold_rdy = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(16'hF800, 1'b1, 1'b0);
        send(16'h07E0, 1'b0, 1'b0);
        send(16'hF800, 1'b0, 1'b1);
        drain();
        check_val("post_rst_ch0", 64'(det_count[0 +: CNT_W]), 2);
        check_val("post_rst_ch1", 64'(det_count[CNT_W +: CNT_W]), 1);

        check_val("end_cnt_queue", 64'(cnt_expq.size() + cntb_expq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
